// File: rtl/mem_pkg.sv
// Shared types and helpers for the CPU-to-RAM access sequencer.
// Mode codes, FSM states and write-data / alignment helpers.
package mem_pkg;

   localparam logic [1:0] MODE_BYTE  = 2'b00;
   localparam logic [1:0] MODE_HALF  = 2'b01;
   localparam logic [1:0] MODE_WORD  = 2'b10;
   localparam logic [1:0] MODE_DWORD = 2'b11;

   localparam int MOC_TIMEOUT_DEF = 15;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      GAP,
      DONE
   } state_t;

   // Natural alignment check per access size
   function automatic logic misaligned(
      input logic [1:0] mode,
      input logic [7:0] addr
   );
      case (mode)
         MODE_HALF:  return addr[0];
         MODE_WORD:  return |addr[1:0];
         MODE_DWORD: return |addr[2:0];
         default:    return 1'b0;
      endcase
   endfunction

   // Right-justified RAM word; a doubleword sends its upper half first
   function automatic logic [31:0] wr_word(
      input logic [1:0]  mode,
      input logic [63:0] wd,
      input logic        second
   );
      case (mode)
         MODE_BYTE: return {24'b0, wd[7:0]};
         MODE_HALF: return {16'b0, wd[15:0]};
         MODE_WORD: return wd[31:0];
         default:   return second ? wd[31:0] : wd[63:32];
      endcase
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load formatter: extends a right-justified RAM word to 64 bits.
// Byte/half/word are sign- or zero-extended; doubleword passes through.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [1:0]  mode,
   input  logic        sgn,
   input  logic [31:0] din,
   output logic [63:0] dout
);

   // Pick the field width and replicate its top bit when signed
   always_comb begin
      dout = '0;
      case (mode)
         MODE_BYTE: dout = {{56{sgn & din[7]}}, din[7:0]};
         MODE_HALF: dout = {{48{sgn & din[15]}}, din[15:0]};
         MODE_WORD: dout = {{32{sgn & din[31]}}, din[31:0]};
         default:   dout = {32'b0, din};
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between CPU datapath and the 256x8 byte RAM.
// One request at a time; doublewords go out as two word transfers.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int MOC_TIMEOUT = MOC_TIMEOUT_DEF
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Req,
   input  logic        RW,
   input  logic [1:0]  Mode,
   input  logic        Signed,
   input  logic [7:0]  Addr,
   input  logic [63:0] WrData,
   output logic [63:0] RdData,
   output logic        Busy,
   output logic        Done,
   output logic        Error,
   output logic        RamEnable,
   output logic        RamReadWrite,
   output logic [7:0]  RamAddress,
   output logic [31:0] RamDataIn,
   output logic [1:0]  RamMode,
   input  logic [31:0] RamDataOut,
   input  logic        Moc
);

   localparam logic [7:0] TO_LAST = 8'(MOC_TIMEOUT - 1);

   state_t      state;
   logic        lat_rw;
   logic [1:0]  lat_mode;
   logic        lat_sgn;
   logic [7:0]  lat_addr;
   logic [63:0] lat_wd;
   logic [7:0]  cnt;
   logic        second;
   logic [31:0] hi;
   logic [63:0] ext;
   logic        is_dw;

   assign is_dw = (lat_mode == MODE_DWORD);

   mem_load_align u_align (
      .mode (lat_mode),
      .sgn  (lat_sgn),
      .din  (RamDataOut),
      .dout (ext)
   );

   // Request FSM with registered RAM-side and CPU-side outputs.
   // IDLE with Busy set is the one-cycle decode slot after accept.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= IDLE;
         lat_rw       <= 1'b1;
         lat_mode     <= MODE_BYTE;
         lat_sgn      <= 1'b0;
         lat_addr     <= '0;
         lat_wd       <= '0;
         cnt          <= '0;
         second       <= 1'b0;
         hi           <= '0;
         RdData       <= '0;
         Busy         <= 1'b0;
         Done         <= 1'b0;
         Error        <= 1'b0;
         RamEnable    <= 1'b0;
         RamReadWrite <= 1'b1;
         RamAddress   <= '0;
         RamDataIn    <= '0;
         RamMode      <= MODE_BYTE;
      end else begin
         case (state)
            IDLE: begin
               if (!Busy) begin
                  if (Req) begin
                     lat_rw   <= RW;
                     lat_mode <= Mode;
                     lat_sgn  <= Signed;
                     lat_addr <= Addr;
                     lat_wd   <= WrData;
                     Busy     <= 1'b1;
                  end
               end else if (misaligned(lat_mode, lat_addr)) begin
                  state <= DONE;
                  Done  <= 1'b1;
                  Error <= 1'b1;
               end else begin
                  state        <= ACCESS;
                  cnt          <= '0;
                  second       <= 1'b0;
                  RamEnable    <= 1'b1;
                  RamReadWrite <= lat_rw;
                  RamAddress   <= lat_addr;
                  RamDataIn    <= wr_word(lat_mode, lat_wd, 1'b0);
                  RamMode      <= is_dw ? MODE_WORD : lat_mode;
               end
            end
            ACCESS: begin
               if (Moc) begin
                  RamEnable <= 1'b0;
                  cnt       <= '0;
                  if (is_dw && !second) begin
                     state <= GAP;
                     hi    <= RamDataOut;
                  end else begin
                     state <= DONE;
                     Done  <= 1'b1;
                     Error <= 1'b0;
                     if (lat_rw)
                        RdData <= is_dw ? {hi, RamDataOut} : ext;
                  end
               end else if (cnt == TO_LAST) begin
                  RamEnable <= 1'b0;
                  cnt       <= '0;
                  state     <= DONE;
                  Done      <= 1'b1;
                  Error     <= 1'b1;
                  RdData    <= '0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            GAP: begin
               state      <= ACCESS;
               cnt        <= '0;
               second     <= 1'b1;
               RamEnable  <= 1'b1;
               RamAddress <= lat_addr + 8'd4;
               RamDataIn  <= wr_word(lat_mode, lat_wd, 1'b1);
            end
            default: begin
               state <= IDLE;
               Done  <= 1'b0;
               Error <= 1'b0;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl with a delayed-MOC RAM model.
// Reference model works on a plain byte array and request-level timing.
module tb_mem_access_ctrl;

   localparam int T = 15;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Req = 1'b0;
   logic        RW = 1'b1;
   logic [1:0]  Mode = 2'b00;
   logic        Signed = 1'b0;
   logic [7:0]  Addr = '0;
   logic [63:0] WrData = '0;
   logic [63:0] RdData;
   logic        Busy, Done, Error;
   logic        RamEnable, RamReadWrite;
   logic [7:0]  RamAddress;
   logic [31:0] RamDataIn;
   logic [1:0]  RamMode;
   logic [31:0] RamDataOut;
   logic        Moc = 1'b0;

   int total = 0;
   int bad = 0;

   logic [7:0]  ram [256];
   logic [7:0]  ref_mem [256];
   logic [63:0] exp_rd = '0;
   int          moc_delay = 0;
   int          en_cnt = 0;
   logic [7:0]  a1, a2, a3;

   mem_access_ctrl #(.MOC_TIMEOUT(T)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Req          (Req),
      .RW           (RW),
      .Mode         (Mode),
      .Signed       (Signed),
      .Addr         (Addr),
      .WrData       (WrData),
      .RdData       (RdData),
      .Busy         (Busy),
      .Done         (Done),
      .Error        (Error),
      .RamEnable    (RamEnable),
      .RamReadWrite (RamReadWrite),
      .RamAddress   (RamAddress),
      .RamDataIn    (RamDataIn),
      .RamMode      (RamMode),
      .RamDataOut   (RamDataOut),
      .Moc          (Moc)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // RAM model: MOC rises moc_delay cycles after Enable
   always @(negedge Clk) begin
      if (RamEnable === 1'b1) en_cnt = en_cnt + 1;
      else en_cnt = 0;
      Moc = (RamEnable === 1'b1) && (en_cnt >= moc_delay + 1);
   end

   assign a1 = RamAddress + 8'd1;
   assign a2 = RamAddress + 8'd2;
   assign a3 = RamAddress + 8'd3;

   always_comb begin
      RamDataOut = '0;
      case (RamMode)
         2'b00:   RamDataOut = {24'b0, ram[RamAddress]};
         2'b01:   RamDataOut = {16'b0, ram[RamAddress], ram[a1]};
         default: RamDataOut = {ram[RamAddress], ram[a1], ram[a2], ram[a3]};
      endcase
   end

   always @(posedge Clk) begin
      if (RamEnable === 1'b1 && Moc && RamReadWrite === 1'b0) begin
         case (RamMode)
            2'b00: ram[RamAddress] = RamDataIn[7:0];
            2'b01: begin
               ram[RamAddress] = RamDataIn[15:8];
               ram[a1] = RamDataIn[7:0];
            end
            default: begin
               ram[RamAddress] = RamDataIn[31:24];
               ram[a1] = RamDataIn[23:16];
               ram[a2] = RamDataIn[15:8];
               ram[a3] = RamDataIn[7:0];
            end
         endcase
      end
   end

   task automatic poke(input logic [7:0] a, input logic [7:0] v);
      ram[a] = v;
      ref_mem[a] = v;
   endtask

   // One CPU request, checked against request-level expectations
   task automatic xact(input logic rw, input logic [1:0] mode,
                       input logic sgn, input logic [7:0] addr,
                       input logic [63:0] wd, input int dly);
      int n, lat, en, exp_lat, exp_en;
      logic mis, to, ok, mode3, seen;
      logic [7:0] first_a, last_a, ba;
      logic [63:0] v;
      n = 1 << mode;
      mis = (int'(addr) % n) != 0;
      to = !mis && (dly >= T);
      ok = !mis && !to;
      if (mis) begin
         exp_lat = 1; exp_en = 0;
      end else if (to) begin
         exp_lat = 1 + T; exp_en = T;
      end else if (mode == 2'b11) begin
         exp_lat = 4 + 2 * dly; exp_en = 2 + 2 * dly;
      end else begin
         exp_lat = 2 + dly; exp_en = 1 + dly;
      end
      @(negedge Clk);
      moc_delay = dly;
      RW = rw; Mode = mode; Signed = sgn; Addr = addr; WrData = wd;
      Req = 1'b1;
      @(posedge Clk); #1;
      check("busy_accept", Busy, 1);
      @(negedge Clk);
      Req = 1'b0;
      lat = 0; en = 0; mode3 = 0; seen = 0;
      first_a = '0; last_a = '0;
      while (lat < 600) begin
         @(posedge Clk); #1;
         lat++;
         if (RamEnable) begin
            en++;
            if (RamMode == 2'b11) mode3 = 1;
            if (!seen) first_a = RamAddress;
            seen = 1;
            last_a = RamAddress;
         end
         if (Done) break;
      end
      check("latency", lat, exp_lat);
      check("en_cycles", en, exp_en);
      check("error", Error, !ok);
      check("busy_done", Busy, 1);
      check("rammode_11", mode3, 0);
      if (!mis) begin
         check("first_addr", first_a, addr);
         check("last_addr", last_a,
               (mode == 2'b11 && !to) ? addr + 8'd4 : addr);
      end
      if (ok && !rw) begin
         for (int i = 0; i < n; i++) begin
            ba = addr + 8'(i);
            ref_mem[ba] = 8'(wd >> (8 * (n - 1 - i)));
         end
      end
      if (ok && rw) begin
         v = '0;
         for (int i = 0; i < n; i++) begin
            ba = addr + 8'(i);
            v = (v << 8) | 64'(ref_mem[ba]);
         end
         if (mode != 2'b11 && sgn && v[8 * n - 1])
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
         exp_rd = v;
      end
      if (to) exp_rd = '0;
      check("rddata", RdData, exp_rd);
      @(posedge Clk); #1;
      check("done_drop", Done, 0);
      check("busy_drop", Busy, 0);
   endtask

   initial begin
      int diffs;
      logic found;
      logic [7:0] ra;
      logic [1:0] rm;
      for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
      repeat (3) @(posedge Clk);
      #1;
      check("rst_rddata", RdData, 0);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_error", Error, 0);
      check("rst_en", RamEnable, 0);
      check("rst_rw", RamReadWrite, 1);
      check("rst_addr", RamAddress, 0);
      check("rst_din", RamDataIn, 0);
      check("rst_mode", RamMode, 0);
      @(negedge Clk);
      Reset = 1'b0;

      poke(8'h10, 8'h80);
      xact(1, 2'b00, 1, 8'h10, 64'd0, 0);
      check("byte_signed", RdData, 64'hFFFF_FFFF_FFFF_FF80);
      xact(1, 2'b00, 0, 8'h10, 64'd0, 0);
      check("byte_unsigned", RdData, 64'h80);

      xact(0, 2'b01, 0, 8'h20, 64'h1234, 1);
      check("ram_20", ram[8'h20], 8'h12);
      check("ram_21", ram[8'h21], 8'h34);
      xact(1, 2'b01, 0, 8'h20, 64'd0, 2);
      check("half_rb", RdData, 64'h1234);

      xact(0, 2'b11, 0, 8'h40, 64'h0123_4567_89AB_CDEF, 0);
      xact(1, 2'b11, 0, 8'h40, 64'd0, 0);
      check("dword_rb", RdData, 64'h0123_4567_89AB_CDEF);

      xact(1, 2'b10, 0, 8'h02, 64'd0, 0);
      check("misal_keep", RdData, 64'h0123_4567_89AB_CDEF);

      xact(1, 2'b10, 1, 8'h30, 64'd0, 255);
      check("timeout_rd", RdData, 0);

      @(negedge Clk);
      moc_delay = 1;
      RW = 1; Mode = 2'b11; Signed = 0; Addr = 8'h80; Req = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Req = 1'b0;
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(posedge Clk); #1;
         if (RamEnable && RamAddress == 8'h84) found = 1;
      end
      check("rst_reach_w2", found, 1);
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk); #1;
      check("mid_rst_en", RamEnable, 0);
      check("mid_rst_busy", Busy, 0);
      check("mid_rst_done", Done, 0);
      @(negedge Clk);
      Reset = 1'b0;
      @(posedge Clk); #1;
      check("post_rst_done", Done, 0);
      exp_rd = '0;
      xact(1, 2'b10, 0, 8'h44, 64'd0, 0);

      for (int k = 0; k < 60; k++) begin
         rm = 2'($urandom);
         ra = 8'($urandom);
         if ($urandom % 3 != 0) ra = ra & ~8'((1 << rm) - 1);
         xact(1'($urandom), rm, 1'($urandom), ra,
              {$urandom, $urandom},
              ($urandom % 10 == 0) ? 255 : int'($urandom % 4));
      end

      diffs = 0;
      for (int i = 0; i < 256; i++)
         if (ram[i] !== ref_mem[i]) diffs++;
      check("mem_image", diffs, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

- Sequencer between the CPU datapath and the 256x8 byte-addressed RAM.
- Accepts one CPU memory request at a time: byte, halfword, word or doubleword; read or write.
- Drives the RAM's Enable/ReadWrite/Address/DataIn/Mode pins and waits for MOC on each transfer.
- Splits each doubleword into two word transfers, and sign- or zero-extends loads to 64 bits.
- Flags misaligned requests and MOC timeouts as errors.

## Interface
Parameters:
- MOC_TIMEOUT, 15: cycles spent in ACCESS without MOC before the transfer is aborted (range 1..255).

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- Req  in  1  CPU request strobe; sampled only in IDLE.
- RW  in  1  1 = read, 0 = write (RAM ReadWrite polarity).
- Mode  in  2  00 byte, 01 halfword, 10 word, 11 doubleword.
- Signed  in  1  read extension: 1 = sign-extend, 0 = zero-extend; ignored for doubleword and writes.
- Addr  in  8  byte address.
- WrData  in  64  write data, right-justified; doubleword uses the full 64 bits.
- RdData  out  64  read result.
- Busy  out  1  request in progress.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  qualifies Done: misaligned or timeout.
- RamEnable  out  1  RAM Enable.
- RamReadWrite  out  1  RAM ReadWrite.
- RamAddress  out  8  RAM Address.
- RamDataIn  out  32  RAM DataIn.
- RamMode  out  2  RAM Mode; never 11.
- RamDataOut  in  32  RAM DataOut.
- Moc  in  1  RAM memory-operation-complete.

## Operation
- States: IDLE, ACCESS, GAP, DONE.
- IDLE:
  - Req=1 latches RW, Mode, Signed, Addr and WrData, and sets Busy.
  - If the request is aligned, go to ACCESS.
  - If misaligned, go straight to DONE with Error=1 and no RAM access. Misaligned means halfword with Addr[0]≠0, word with Addr[1:0]≠0, or doubleword with Addr[2:0]≠0.
- ACCESS:
  - RamEnable=1.
  - RamMode = latched Mode, or 10 for a doubleword.
  - RamAddress = Addr for the first word, Addr+4 for the second.
  - The timeout counter increments each cycle.
  - On Moc=1:
    - Read: capture RamDataOut.
    - Doubleword first half: go to GAP.
    - Otherwise: go to DONE.
  - When the counter reaches MOC_TIMEOUT with Moc still 0: go to DONE with Error=1 and RdData=0.
- GAP:
  - RamEnable=0 for exactly one cycle; the counter clears.
  - Then return to ACCESS for the second word.
- DONE:
  - Done=1 for one cycle, Error valid alongside it.
  - Busy stays high through DONE.
  - Then go to IDLE.
- Write data on RamDataIn:
  - Byte: {24'b0, WrData[7:0]}.
  - Halfword: {16'b0, WrData[15:0]}.
  - Word: WrData[31:0].
  - Doubleword: WrData[63:32] first, then WrData[31:0]. Storage is big-endian.
- Read formatting:
  - Byte: RamDataOut[7:0] extended to 64 bits per Signed.
  - Halfword: RamDataOut[15:0] extended per Signed.
  - Word: RamDataOut[31:0] extended per Signed.
  - Doubleword: first word goes to RdData[63:32], second to [31:0].
- RdData:
  - Updated only at read completion or on timeout (cleared).
  - Held until the next read completes. Writes leave it unchanged.
- Req in any state other than IDLE is ignored; there is no queueing.
- Addresses never wrap: alignment guarantees Addr+7 ≤ 0xFF.

## Timing
- Reset values: RdData=0, Busy=0, Done=0, Error=0, RamEnable=0, RamReadWrite=1, RamAddress=0, RamDataIn=0, RamMode=00. State = IDLE.
- Reset mid-transfer: RamEnable drops at that edge and no Done is issued.
- Req is sampled at edge k:
  - Busy=1 from k.
  - RamEnable=1 from k+1.
- Earliest single-transfer completion: Moc=1 sampled at edge k+2 gives Done high from k+2 to k+3; Busy falls at k+3.
- Doubleword with immediate Moc:
  - ACCESS k+1..k+2.
  - GAP k+2..k+3.
  - ACCESS k+3..k+4.
  - Done k+4..k+5.
- Misaligned request: Done and Error high from k+1 to k+2; RamEnable stays 0 throughout.
- Timeout: RamEnable high for exactly MOC_TIMEOUT cycles, then Done and Error follow.
- Moc is sampled only in ACCESS. Moc=1 in IDLE or GAP has no effect.
- All RAM-side outputs are registered and stable for the whole time RamEnable is high.

## Structure
- Package mem_pkg holds:
  - Mode localparams: MODE_BYTE, MODE_HALF, MODE_WORD, MODE_DWORD.
  - The state enum.
  - The MOC_TIMEOUT default.
- Sub-module mem_load_align: combinational 32→64 extension selected by Mode and Signed. Instantiated once on the capture path.
- Top level holds the FSM, the timeout counter, the request latches and the RdData register.

## Test plan
The bench drives a RAM model with a configurable MOC delay.
- Byte read, Signed=1, Addr=0x10, memory 0x80 → RdData=0xFFFF_FFFF_FFFF_FF80. Repeated with Signed=0 → 0x0000_0000_0000_0080. Done 2 cycles after accept when MOC delay is 0.
- Halfword write then read, Addr=0x20, WrData=0x1234 → RAM[0x20]=0x12, RAM[0x21]=0x34. Readback with Signed=0 → RdData=0x1234.
- Doubleword write, Addr=0x40, WrData=0x0123_4567_89AB_CDEF → two ACCESS phases at 0x40 and 0x44 separated by one GAP cycle. Readback → identical 64-bit value. Done at k+4.
- Misaligned word, Addr=0x02 → Done and Error at k+1. RamEnable never asserts; RdData unchanged.
- Moc held at 0 with MOC_TIMEOUT=15 → RamEnable high for exactly 15 cycles, then Done=1, Error=1, RdData=0.
- Reset asserted during the second word of a doubleword → RamEnable=0 and Busy=0 after that edge, no Done pulse. A following Req is accepted normally.
